// File: rtl/lc3b_types.sv
// Shared types for the cache controller: way index, controller state, counter width.
package lc3b_types;
  localparam int CNT_W = 16;

  typedef logic [1:0] lc3b_way;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_e;

  // Lowest-numbered asserted hit bit wins when the datapath reports several.
  function automatic lc3b_way first_hit(input logic [3:0] h);
    lc3b_way w;
    w = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (h[i]) w = lc3b_way'(i);
    return w;
  endfunction
endpackage

// File: rtl/sat_counter16.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module sat_counter16
  import lc3b_types::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (en_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
endmodule

// File: rtl/cache_control.sv
// 4-way cache controller: zero-latency hit in CHECK, dirty-victim writeback, line allocate.
module cache_control
  import lc3b_types::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [3:0]       hit,
  input  logic [1:0]       lru,
  input  logic             victim_dirty,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [1:0]       way_sel,
  output logic             load_data,
  output logic             load_tag,
  output logic             set_valid,
  output logic             set_dirty,
  output logic             clear_dirty,
  output logic             pmem_addr_sel,
  output logic             fill_sel,
  output logic             lru_write,
  output logic [1:0]       lru_index,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  cache_state_e state_q, state_d;
  lc3b_way      victim_q, victim_d;
  logic         fill_q, fill_d;
  logic         req, hit_inc, miss_inc;
  lc3b_way      hit_way;

  assign req     = mem_read | mem_write;
  assign hit_way = first_hit(hit);

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    fill_d        = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    way_sel       = 2'd0;
    load_data     = 1'b0;
    load_tag      = 1'b0;
    set_valid     = 1'b0;
    set_dirty     = 1'b0;
    clear_dirty   = 1'b0;
    pmem_addr_sel = 1'b0;
    fill_sel      = 1'b0;
    lru_write     = 1'b0;
    lru_index     = 2'd0;
    unique case (state_q)
      CHECK: begin
        if (req && |hit) begin
          mem_resp  = 1'b1;
          way_sel   = hit_way;
          lru_write = 1'b1;
          lru_index = hit_way;
          // Simultaneous read+write is a write.
          if (mem_write) begin
            load_data = 1'b1;
            set_dirty = 1'b1;
          end
          // The retry right after a fill belongs to the miss already counted.
          hit_inc = ~fill_q;
        end else if (req) begin
          victim_d = lru;
          way_sel  = lru;
          miss_inc = 1'b1;
          state_d  = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (pmem_resp) begin
          load_data   = 1'b1;
          load_tag    = 1'b1;
          set_valid   = 1'b1;
          clear_dirty = 1'b1;
          fill_sel    = 1'b1;
          fill_d      = 1'b1;
          state_d     = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= CHECK;
      victim_q <= 2'd0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      fill_q   <= fill_d;
    end
  end

  sat_counter16 u_hit_cnt (
    .clk(clk), .rst(reset), .en_i(hit_inc), .clr_i(1'b0), .count_o(hit_count)
  );

  sat_counter16 u_miss_cnt (
    .clk(clk), .rst(reset), .en_i(miss_inc), .clr_i(1'b0), .count_o(miss_count)
  );
endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: stimulus queues expected responses/fills, a monitor pops and checks.
module tb_cache_control;
  logic        clk, reset;
  logic        mem_read, mem_write, victim_dirty, pmem_resp;
  logic [3:0]  hit;
  logic [1:0]  lru;
  logic        mem_resp, pmem_read, pmem_write;
  logic [1:0]  way_sel, lru_index;
  logic        load_data, load_tag, set_valid, set_dirty, clear_dirty;
  logic        pmem_addr_sel, fill_sel, lru_write;
  logic [15:0] hit_count, miss_count;

  typedef struct { logic [1:0] way; logic wr; } resp_t;
  resp_t      resp_q[$];
  logic [1:0] exp_fill_q[$];
  int  n_cmp = 0, n_bad = 0;
  bit  bulk = 0;
  int  exp_hits = 0, exp_miss = 0;

  cache_control dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .hit(hit), .lru(lru), .victim_dirty(victim_dirty), .pmem_resp(pmem_resp),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .way_sel(way_sel), .load_data(load_data), .load_tag(load_tag),
    .set_valid(set_valid), .set_dirty(set_dirty), .clear_dirty(clear_dirty),
    .pmem_addr_sel(pmem_addr_sel), .fill_sel(fill_sel), .lru_write(lru_write),
    .lru_index(lru_index), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every CPU response and every line fill must match a queued expectation.
  always @(negedge clk) begin
    if (!reset && !bulk) begin
      if (mem_resp) begin
        if (resp_q.size() == 0) chk("unexpected_mem_resp", 1, 0);
        else begin
          resp_t e;
          e = resp_q.pop_front();
          chk("resp_way_sel", {30'd0, way_sel}, {30'd0, e.way});
          chk("resp_lru_index", {30'd0, lru_index}, {30'd0, e.way});
          chk("resp_lru_write", {31'd0, lru_write}, 1);
          chk("resp_load_data", {31'd0, load_data}, {31'd0, e.wr});
          chk("resp_set_dirty", {31'd0, set_dirty}, {31'd0, e.wr});
          chk("resp_fill_sel", {31'd0, fill_sel}, 0);
        end
      end
      if (load_tag) begin
        if (exp_fill_q.size() == 0) chk("unexpected_fill", 1, 0);
        else begin
          logic [1:0] w;
          w = exp_fill_q.pop_front();
          chk("fill_way_sel", {30'd0, way_sel}, {30'd0, w});
          chk("fill_strobes", {27'd0, load_data, set_valid, clear_dirty, fill_sel, set_dirty}, 32'b11110);
          chk("fill_pmem_read", {31'd0, pmem_read}, 1);
        end
      end
      if (load_data && !mem_resp && !load_tag) chk("stray_load_data", 1, 0);
    end
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic idle();
    mem_read = 0; mem_write = 0; hit = 4'd0; pmem_resp = 0; victim_dirty = 0;
  endtask

  task automatic do_hit(input logic rd, input logic wr, input logic [3:0] h, input logic [1:0] w);
    resp_t e;
    e.way = w; e.wr = wr;
    resp_q.push_back(e);
    mem_read = rd; mem_write = wr; hit = h;
    step();
    idle();
  endtask

  // Miss; victim writeback (if dirty) over wb_cyc cycles, allocate over al_cyc cycles,
  // then the retried request hits the filled way (skipped when the CPU drops the request).
  task automatic do_miss(input logic wr, input logic [1:0] l, input logic dirty,
                         input int wb_cyc, input int al_cyc, input logic drop);
    resp_t e;
    mem_read = ~wr; mem_write = wr; hit = 4'd0; lru = l; victim_dirty = dirty;
    @(negedge clk);
    chk("miss_way_sel", {30'd0, way_sel}, {30'd0, l});
    chk("miss_no_pmem", {30'd0, pmem_read, pmem_write}, 0);
    step();
    exp_miss++;
    lru = ~l; victim_dirty = 0;
    if (drop) begin mem_read = 0; mem_write = 0; end
    if (dirty) begin
      for (int i = 0; i < wb_cyc; i++) begin
        pmem_resp = (i == wb_cyc - 1);
        @(negedge clk);
        chk("wb_strobes", {29'd0, pmem_write, pmem_addr_sel, pmem_read}, 32'b110);
        chk("wb_way_sel", {30'd0, way_sel}, {30'd0, l});
        step();
      end
    end
    for (int i = 0; i < al_cyc; i++) begin
      pmem_resp = (i == al_cyc - 1);
      if (pmem_resp) exp_fill_q.push_back(l);
      @(negedge clk);
      chk("alloc_strobes", {29'd0, pmem_write, pmem_addr_sel, pmem_read}, 32'b001);
      chk("alloc_way_sel", {30'd0, way_sel}, {30'd0, l});
      if (!pmem_resp) chk("alloc_no_load", {31'd0, load_data}, 0);
      step();
    end
    pmem_resp = 0;
    if (!drop) begin
      e.way = l; e.wr = wr;
      resp_q.push_back(e);
      hit = 4'(1) << l;
      step();
    end
    idle();
    @(negedge clk);
    chk("idle_way_sel", {30'd0, way_sel}, 0);
    chk("miss_count", {16'd0, miss_count}, exp_miss);
    chk("hit_count_after_fill", {16'd0, hit_count}, exp_hits);
    step();
  endtask

  initial begin
    reset = 1; lru = 0; idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_counters", {hit_count, miss_count}, 0);
    chk("reset_strobes", {20'd0, mem_resp, pmem_read, pmem_write, load_data, load_tag, set_valid,
                          set_dirty, clear_dirty, pmem_addr_sel, fill_sel, lru_write, way_sel != 0}, 0);
    reset = 0;
    @(negedge clk);
    chk("idle_way_sel", {30'd0, way_sel}, 0);
    step();

    do_hit(1, 0, 4'b0100, 2'd2); exp_hits++;
    chk("hit_count_read", {16'd0, hit_count}, exp_hits);
    do_hit(1, 0, 4'b1010, 2'd1); exp_hits++;
    do_hit(1, 1, 4'b0001, 2'd0); exp_hits++;
    chk("hit_count_3", {16'd0, hit_count}, exp_hits);

    do_miss(0, 2'd3, 0, 0, 5, 0);
    do_miss(1, 2'd1, 1, 3, 3, 0);
    do_miss(0, 2'd2, 0, 0, 4, 1);

    // Reset in the middle of an allocate.
    mem_read = 1; hit = 4'd0; lru = 2'd0;
    step();
    exp_miss++;
    @(negedge clk);
    chk("pre_reset_pmem_read", {31'd0, pmem_read}, 1);
    chk("pre_reset_miss_count", {16'd0, miss_count}, exp_miss);
    step();
    reset = 1; idle();
    #1;
    chk("reset_mid_alloc_pmem_read", {31'd0, pmem_read}, 0);
    chk("reset_mid_alloc_counters", {hit_count, miss_count}, 0);
    step();
    reset = 0; pmem_resp = 1;
    @(negedge clk);
    chk("stray_pmem_resp", {29'd0, load_data, load_tag, mem_resp}, 0);
    step();
    pmem_resp = 0;
    do_hit(1, 0, 4'b1000, 2'd3);
    chk("hit_after_reset", {16'd0, hit_count}, 1);

    // Saturation of the hit counter.
    bulk = 1; mem_read = 1; hit = 4'b0001;
    repeat (65540) @(posedge clk);
    #1;
    chk("hit_count_sat", {16'd0, hit_count}, 32'hFFFF);
    step();
    chk("hit_count_hold", {16'd0, hit_count}, 32'hFFFF);
    idle();
    bulk = 0;
    step();

    chk("resp_queue_drained", resp_q.size(), 0);
    chk("fill_queue_drained", exp_fill_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have: clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: mem_read, mem_write  input  1 each  CPU request strobes, held until mem_resp.
REQ-004 SHALL have: hit  input  4  per-way tag-match AND valid from the cache datapath.
REQ-005 SHALL have: lru  input  2  least-recently-used way from the LRU stack of the addressed set.
REQ-006 SHALL have: victim_dirty  input  1  dirty bit of the way selected by way_sel.
REQ-007 SHALL have: pmem_resp  input  1  physical memory completion, one-cycle pulse.
REQ-008 SHALL have: mem_resp  output  1  CPU completion, one-cycle pulse.
REQ-009 SHALL have: pmem_read, pmem_write  output  1 each  physical memory strobes.
REQ-010 SHALL have: way_sel  output  2  way addressed by the datapath this cycle.
REQ-011 SHALL have: load_data, load_tag, set_valid, set_dirty, clear_dirty  output  1 each  datapath array write enables for way_sel.
REQ-012 SHALL have: pmem_addr_sel  output  1  0 = CPU address, 1 = {victim tag, set} for writeback.
REQ-013 SHALL have: fill_sel  output  1  0 = CPU write data merge, 1 = pmem line fill.
REQ-014 SHALL have: lru_write  output  1 and lru_index  output  2  update for the LRU stack (index becomes MRU).
REQ-015 SHALL have: hit_count, miss_count  output  16 each  performance counters.

Function
REQ-016 SHALL implement states CHECK, WRITEBACK, ALLOCATE; reset state CHECK.
REQ-017 CHECK, request with exactly one hit bit: mem_resp=1, way_sel=hit way, lru_write=1, lru_index=hit way, same cycle (zero-cycle hit latency); stay CHECK.
REQ-018 CHECK write hit: additionally load_data=1, set_dirty=1, fill_sel=0.
REQ-019 Multiple hit bits SHALL resolve to the lowest-numbered way.
REQ-020 CHECK miss: latch victim=lru into register; way_sel=lru; next state WRITEBACK if victim_dirty else ALLOCATE; increment miss_count once per miss.
REQ-021 WRITEBACK: pmem_write=1, pmem_addr_sel=1, way_sel=victim; on pmem_resp go ALLOCATE.
REQ-022 ALLOCATE: pmem_read=1, pmem_addr_sel=0, way_sel=victim; on pmem_resp assert load_data, load_tag, set_valid, clear_dirty, fill_sel=1 for one cycle, return CHECK.
REQ-023 Request retried in CHECK after fill SHALL hit; hit_count increments only on hits not immediately following a fill.
REQ-024 mem_read and mem_write both high SHALL be treated as write.
REQ-025 Request deasserted during WRITEBACK/ALLOCATE: sequence SHALL still complete; no mem_resp issued.
REQ-026 Counters SHALL saturate at 16'hFFFF.
REQ-027 Outputs not named active in a state SHALL be 0; way_sel SHALL be 0 in CHECK with no request.

Reset
REQ-028 Reset SHALL force CHECK, victim=0, counters=0, all strobes 0, including mid-WRITEBACK/ALLOCATE; a pending pmem_resp after reset SHALL be ignored.

Structure
REQ-029 lc3b_types SHALL hold lc3b_way (2-bit) and cache state enum; counter width constant 16.
REQ-030 One sub-module sat_counter16 (enable, clear, saturating) SHALL be instantiated twice.

Verification
REQ-031 Read, hit=4'b0100 -> same-cycle mem_resp=1, lru_write=1, lru_index=2, hit_count=1.
REQ-032 Read miss, lru=3, victim_dirty=0 -> ALLOCATE, pmem_read until pmem_resp after 5 cycles, fill on way 3, next cycle hit, miss_count=1.
REQ-033 Write miss, lru=1, victim_dirty=1 -> pmem_write with pmem_addr_sel=1, then pmem_read, then write hit with set_dirty=1 on way 1.
REQ-034 hit=4'b1010 -> way_sel=1, lru_index=1.
REQ-035 Reset asserted mid-ALLOCATE -> pmem_read=0 immediately, state CHECK, counters 0; stray pmem_resp produces no load_data.
REQ-036 65,536 consecutive hits -> hit_count holds 16'hFFFF.
